y_mux_rr_feeder: RTL and testbench
==================================

Y_MUX_RR_FEEDER -- requirements
Module: y_mux_rr_feeder

Purpose: round-robin sequencer upstream/downstream of the 4-to-1 data mux (yMux4to1). Drives the mux 2-bit select, captures the muxed word, and presents it on a valid/ready output.

Interface
REQ-001 SHALL have parameter W, default 8, giving the data width of the mux output and the captured word.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `req`, input, 4 bits: req[i]=1 means mux source i holds a word to deliver.
REQ-005 SHALL have port `sel`, output, 2 bits: registered select, wired to the mux `c` input.
REQ-006 SHALL have port `mux_z`, input, W bits: the mux output `z`.
REQ-007 SHALL have port `gnt`, output, 4 bits: one-hot acknowledgement, a 1-cycle pulse for the consumed source.
REQ-008 SHALL have port `out_data`, output, W bits: the captured word.
REQ-009 SHALL have port `out_valid`, output, 1 bit: out_data holds an undelivered word.
REQ-010 SHALL have port `out_ready`, input, 1 bit: the consumer accepts out_data on an edge where out_valid=1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SAMPLE and HOLD, plus a 2-bit round-robin pointer `ptr`.
REQ-012 Arbitration SHALL use priority order ptr, ptr+1, ptr+2, ptr+3, all mod 4; the first set req bit in that order is the winner.
REQ-013 IDLE: if req!=0 at the edge, then sel<=winner and state<=SAMPLE; otherwise the block SHALL remain in IDLE with sel unchanged.
REQ-014 SAMPLE: at the edge, the block SHALL perform all of:
- out_data<=mux_z
- out_valid<=1
- gnt<=one-hot(sel) for exactly one cycle
- ptr<=sel+1 mod 4 (3 wraps to 0)
- state<=HOLD
REQ-015 SAMPLE SHALL NOT re-check req; a req drop after selection SHALL still yield a capture. Sources SHALL hold req until they see gnt.
REQ-016 HOLD with out_ready=0: out_valid, out_data and sel SHALL stay unchanged, and mux_z changes SHALL be ignored.
REQ-017 HOLD with out_ready=1 and req=0: out_valid<=0 and state<=IDLE.
REQ-018 HOLD with out_ready=1 and req!=0: out_valid<=0, sel<=winner (using the updated ptr) and state<=SAMPLE. This gives back-to-back delivery of one word per 2 cycles.
REQ-019 Latency: req seen at edge N gives sel valid after edge N, and out_valid=1 with out_data and gnt after edge N+1.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 gnt SHALL be 0 in every cycle except the one following a SAMPLE edge, and SHALL have at most one bit set.
REQ-022 out_data SHALL change only on a SAMPLE edge or on reset.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL force:
- state=IDLE, ptr=0, sel=0
- out_data=0, out_valid=0, gnt=0
REQ-024 Reset asserted in SAMPLE or HOLD SHALL discard the pending word; no gnt SHALL follow.
REQ-025 After rst falls, the first arbitration SHALL occur at the first rising clk edge with req!=0, with priority starting at source 0.

Verification (W=8; the bench models the mux as z = source[sel])
REQ-026 Reset, then req=0001 and source0=8'hA5: sel=0 after edge 1; after edge 2, out_valid=1, out_data=8'hA5 and gnt=0001 for 1 cycle.
REQ-027 req=1111 held and out_ready=1: sel sequence 0,1,2,3,0; gnt pulses 0001,0010,0100,1000,0001; one word every 2 cycles.
REQ-028 Wrap-around: after a grant to source 1 (ptr=2), req=0011 SHALL give winner 0; after a grant to source 3, ptr SHALL be 0.
REQ-029 Backpressure: in HOLD with out_data=8'h3C, out_ready=0 for 5 cycles while source values change: out_valid stays 1, out_data stays 8'h3C, sel is unchanged and gnt=0.
REQ-030 Reset mid-HOLD: rst pulsed between clk edges SHALL immediately give out_valid=0, out_data=8'h00, sel=0 and gnt=0; the next grant with req=1010 SHALL go to source 1.
REQ-031 HOLD with out_ready=1 and req=0100 on the same edge: out_valid falls and sel=2; on the next edge, out_valid=1 with source2's word and gnt=0100.

Source files
------------

// File: rtl/y_mux_rr_feeder.sv
// Round-robin sequencer around a 4-to-1 mux: picks a requesting source, drives the
// mux select, captures the muxed word and offers it on a valid/ready output.
module y_mux_rr_feeder #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [1:0]   sel,
  input  logic [W-1:0] mux_z,
  output logic [3:0]   gnt,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;

  // First set request scanning from ptr upward, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      gnt       <= 4'd0;
    end else begin
      gnt <= 4'd0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= winner;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Request is not re-checked here; the source committed when selected.
          out_data  <= mux_z;
          out_valid <= 1'b1;
          gnt       <= 4'b0001 << sel;
          ptr       <= sel + 2'd1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (|req) begin
              sel   <= winner;
              state <= SAMPLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_mux_rr_feeder.sv
// Bench for y_mux_rr_feeder: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the feeder and mux.
module tb_y_mux_rr_feeder;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] sel;
  logic [7:0] mux_z;
  logic [3:0] gnt;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] src [4];

  int vectors;
  int miscompares;

  assign mux_z = src[sel];

  y_mux_rr_feeder #(.W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .sel(sel), .mux_z(mux_z),
    .gnt(gnt), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a word is either being fetched (pending), waiting at the output, or absent.
  logic [1:0] m_sel, m_ptr;
  logic [7:0] m_data;
  logic       m_valid, m_pending;
  logic [3:0] m_gnt;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (int'(p) + k) % 4;
      if (r[j]) return 2'(j);
    end
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel <= 2'd0; m_ptr <= 2'd0; m_data <= 8'd0;
      m_valid <= 1'b0; m_pending <= 1'b0; m_gnt <= 4'd0;
    end else begin
      m_gnt <= 4'd0;
      if (m_pending) begin
        m_data    <= src[m_sel];
        m_valid   <= 1'b1;
        m_gnt     <= 4'(1 << m_sel);
        m_ptr     <= 2'((int'(m_sel) + 1) % 4);
        m_pending <= 1'b0;
      end else if (!m_valid || out_ready) begin
        m_valid <= 1'b0;
        if (req != 4'd0) begin
          m_sel     <= pick(req, m_ptr);
          m_pending <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    vectors++;
    if (sel !== m_sel || gnt !== m_gnt || out_valid !== m_valid ||
        (m_valid && out_data !== m_data) || (!m_valid && out_data !== m_data)) begin
      miscompares++;
      $display("FAIL model_cmp: sel=%0d/%0d gnt=%b/%b valid=%b/%b data=%h/%h at %0t",
               sel, m_sel, gnt, m_gnt, out_valid, m_valid, out_data, m_data, $time);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req = 4'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) src[k] = 8'd0;
    #3;
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_out", {23'd0, out_valid, out_data}, 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);

    // Single request from source 0.
    cyc(); #1; rst = 1'b0; src[0] = 8'hA5; req = 4'b0001;
    cyc(); chk("first_sel", 32'(sel), 32'd0); chk("first_valid_low", 32'(out_valid), 32'd0);
    cyc(); chk("first_valid", 32'(out_valid), 32'd1); chk("first_data", 32'(out_data), 32'hA5);
    chk("first_gnt", 32'(gnt), 32'b0001);
    #1; req = 4'd0;
    cyc(); chk("gnt_one_cycle", 32'(gnt), 32'd0);
    #1; out_ready = 1'b1;
    cyc(); chk("drain_valid", 32'(out_valid), 32'd0);

    // All sources requesting: full rotation from a fresh pointer.
    #1; pulse_rst(); req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cyc(); chk("rr_sel", 32'(sel), 32'(n % 4));
      cyc(); chk("rr_gnt", 32'(gnt), 32'(1 << (n % 4)));
    end

    // Backpressure while source values move.
    #1; pulse_rst(); out_ready = 1'b0; src[0] = 8'h3C; req = 4'b0001;
    cyc(); cyc(); chk("bp_capture", 32'(out_data), 32'h3C);
    #1; req = 4'd0;
    for (int n = 0; n < 5; n++) begin
      src[0] = 8'($urandom); src[1] = 8'($urandom);
      cyc();
      chk("bp_hold", {20'd0, gnt, out_valid, sel, out_data}, {20'd0, 4'd0, 1'b1, 2'd0, 8'h3C});
      #1;
    end

    // Asynchronous reset mid-HOLD, then the next grant starts from source 0 priority.
    rst = 1'b1; #1;
    chk("async_rst", {20'd0, gnt, out_valid, sel, out_data}, 32'd0);
    rst = 1'b0; src[1] = 8'h11; src[3] = 8'h33; req = 4'b1010;
    cyc(); cyc(); chk("post_rst_gnt", 32'(gnt), 32'b0010);

    // Pointer now 2: source 0 wins over source 1.
    #1; out_ready = 1'b1; req = 4'b0011;
    cyc(); chk("wrap_sel", 32'(sel), 32'd0);
    cyc(); chk("wrap_gnt", 32'(gnt), 32'b0001);
    #1; req = 4'b1000;
    cyc(); cyc(); chk("src3_gnt", 32'(gnt), 32'b1000);
    #1; req = 4'b1111;
    cyc(); chk("ptr_wrap0", 32'(sel), 32'd0);
    cyc(); chk("ptr_wrap0_gnt", 32'(gnt), 32'b0001);

    // Release and reselect on the same edge.
    #1; src[2] = 8'h5A; req = 4'b0100;
    cyc(); chk("b2b_valid_low", 32'(out_valid), 32'd0); chk("b2b_sel", 32'(sel), 32'd2);
    cyc(); chk("b2b_data", 32'(out_data), 32'h5A); chk("b2b_gnt", 32'(gnt), 32'b0100);
    chk("b2b_valid", 32'(out_valid), 32'd1);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 2000; n++) begin
      #1;
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'd0;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) src[k] = 8'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_rst();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
